// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the pipelined RV32I core.
// Holds the PC and drives the instruction memory and the BHT lookup. It forms
// the next PC from the BHT taken bit and a direct-mapped BTB, then registers the
// fetched instruction into IF/ID. When EX reports a mispredict, it redirects
// the PC and flushes IF/ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          BTB_SIZE     = 64,
  parameter int          BTB_IDX_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] bht_addr,
  input  logic        bht_taken,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_pred_taken,
  output logic [31:0] if_id_pred_target
);

  localparam int          TAG_W  = 30 - BTB_IDX_BITS;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] PC_RST = {RESET_PC[31:2], 2'b00};

  // BTB storage: only the valid bits need a reset; tag/target are qualified by valid.
  logic [BTB_SIZE-1:0] r_btb_valid;
  logic [TAG_W-1:0]    r_btb_tag    [BTB_SIZE];
  logic [29:0]         r_btb_target [BTB_SIZE];

  logic [31:0] r_pc;
  logic        r_if_id_valid;
  logic [31:0] r_if_id_instr;
  logic [31:0] r_if_id_pc;
  logic        r_if_id_pred_taken;
  logic [31:0] r_if_id_pred_target;

  logic [BTB_IDX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]        w_tag;
  logic                    w_hit;
  logic                    w_pred;
  logic [31:0]             w_btb_tgt;
  logic [31:0]             w_pred_next;
  logic [BTB_IDX_BITS-1:0] w_ex_idx;
  logic                    w_btb_wr;
  logic [31:0]             w_fix_next;
  logic                    w_unused;

  // Lookup side: the BTB is read with the current PC.
  assign w_idx       = r_pc[BTB_IDX_BITS+1:2];
  assign w_tag       = r_pc[31:BTB_IDX_BITS+2];
  assign w_hit       = r_btb_valid[w_idx] && (r_btb_tag[w_idx] == w_tag);
  // A BHT "taken" without a BTB hit has no target, so fall back to not-taken.
  assign w_pred      = bht_taken && w_hit;
  assign w_btb_tgt   = {r_btb_target[w_idx], 2'b00};
  assign w_pred_next = w_pred ? w_btb_tgt : (r_pc + 32'd4);

  // Resolve side. The low two address bits are never meaningful, so compare only [31:2].
  assign w_ex_idx   = ex_pc[BTB_IDX_BITS+1:2];
  assign w_btb_wr   = ex_valid && ex_taken;
  assign mispredict = ex_valid && ((ex_taken != ex_pred_taken) ||
                      (ex_taken && (ex_pred_target[31:2] != ex_target[31:2])));
  assign w_fix_next = ex_taken ? {ex_target[31:2], 2'b00}
                               : {ex_pc[31:2] + 30'd1, 2'b00};

  assign w_unused = ^{ex_pc[1:0], ex_target[1:0], ex_pred_target[1:0]};

  assign imem_addr         = r_pc;
  assign bht_addr          = r_pc;
  assign if_id_valid       = r_if_id_valid;
  assign if_id_instr       = r_if_id_instr;
  assign if_id_pc          = r_if_id_pc;
  assign if_id_pred_taken  = r_if_id_pred_taken;
  assign if_id_pred_target = r_if_id_pred_target;

  // BTB valid bits: set on any taken resolution; stall does not block training.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_btb_valid           <= '0;
    else if (w_btb_wr) r_btb_valid[w_ex_idx] <= 1'b1;
  end

  // BTB tag/target write; a same-cycle lookup sees the pre-edge contents.
  always_ff @(posedge clk) begin
    if (w_btb_wr) begin
      r_btb_tag[w_ex_idx]    <= ex_pc[31:BTB_IDX_BITS+2];
      r_btb_target[w_ex_idx] <= ex_target[31:2];
    end
  end

  // PC and IF/ID register. Priority: reset, then redirect, then stall, then advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc                <= PC_RST;
      r_if_id_valid       <= 1'b0;
      r_if_id_instr       <= NOP;
      r_if_id_pc          <= '0;
      r_if_id_pred_taken  <= 1'b0;
      r_if_id_pred_target <= '0;
    end else if (mispredict) begin
      r_pc                <= w_fix_next;
      r_if_id_valid       <= 1'b0;
      r_if_id_instr       <= NOP;
      r_if_id_pc          <= '0;
      r_if_id_pred_taken  <= 1'b0;
      r_if_id_pred_target <= '0;
    end else if (!stall) begin
      r_pc                <= w_pred_next;
      r_if_id_valid       <= 1'b1;
      r_if_id_instr       <= imem_rdata;
      r_if_id_pc          <= r_pc;
      r_if_id_pred_taken  <= w_pred;
      r_if_id_pred_target <= w_pred ? w_btb_tgt : 32'd0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. Instruction memory is modelled as
// instr = addr ^ 32'hDEAD_0000, so every fetched word identifies its address.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] imem_addr, imem_rdata, bht_addr;
  logic        bht_taken;
  logic        ex_valid, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        mispredict;
  logic        if_id_valid, if_id_pred_taken;
  logic [31:0] if_id_instr, if_id_pc, if_id_pred_target;

  int total = 0;
  int bad   = 0;

  fetch_stage #(.RESET_PC(32'h0000_0100), .BTB_SIZE(64), .BTB_IDX_BITS(6)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .bht_addr(bht_addr), .bht_taken(bht_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_pred_taken(if_id_pred_taken), .if_id_pred_target(if_id_pred_target)
  );

  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ex_clear();
    ex_valid = 0; ex_pc = 0; ex_taken = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
  endtask

  // Drive a not-taken resolution that was predicted taken: redirects to pc+4, no BTB write.
  task automatic redirect_nt(input logic [31:0] pc);
    ex_valid = 1; ex_pc = pc; ex_taken = 0; ex_pred_taken = 1; ex_pred_target = 32'h0000_0300;
    tick();
    ex_clear();
  endtask

  task automatic test_reset();
    reset = 1; stall = 0; bht_taken = 0; ex_clear();
    tick(); tick();
    total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL rst_pc got=%h exp=%h", imem_addr, 32'h100); end
    total++; if (bht_addr !== 32'h100) begin bad++; $display("FAIL rst_bht_addr got=%h exp=%h", bht_addr, 32'h100); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", if_id_valid); end
    total++; if (if_id_instr !== 32'h13) begin bad++; $display("FAIL rst_instr got=%h exp=00000013", if_id_instr); end
    total++; if ({if_id_pc, if_id_pred_target} !== 64'd0 || if_id_pred_taken !== 1'b0) begin bad++;
      $display("FAIL rst_pc_pred got=%h/%b/%h exp=0/0/0", if_id_pc, if_id_pred_taken, if_id_pred_target); end
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL rst_mispredict got=%b exp=0", mispredict); end
    reset = 0;
  endtask

  task automatic test_sequential();
    total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL seq0 got=%h exp=100", imem_addr); end
    tick();
    total++; if (imem_addr !== 32'h104) begin bad++; $display("FAIL seq1_pc got=%h exp=104", imem_addr); end
    total++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100) begin bad++;
      $display("FAIL seq1_ifid got=%b/%h exp=1/100", if_id_valid, if_id_pc); end
    total++; if (if_id_instr !== 32'hDEAD_0100) begin bad++; $display("FAIL seq1_instr got=%h exp=dead0100", if_id_instr); end
    tick();
    total++; if (imem_addr !== 32'h108 || if_id_pc !== 32'h104) begin bad++;
      $display("FAIL seq2 got=%h/%h exp=108/104", imem_addr, if_id_pc); end
  endtask

  task automatic test_mispredict();
    ex_valid = 1; ex_pc = 32'h108; ex_taken = 1; ex_target = 32'h200; ex_pred_taken = 0; ex_pred_target = 0;
    #1;
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL mp_flag got=%b exp=1", mispredict); end
    tick();
    ex_clear(); #1;
    total++; if (imem_addr !== 32'h200) begin bad++; $display("FAIL mp_pc got=%h exp=200", imem_addr); end
    total++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13) begin bad++;
      $display("FAIL mp_flush got=%b/%h exp=0/00000013", if_id_valid, if_id_instr); end
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL mp_clear got=%b exp=0", mispredict); end
    tick();
    total++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h200 || imem_addr !== 32'h204) begin bad++;
      $display("FAIL mp_resume got=%b/%h/%h exp=1/200/204", if_id_valid, if_id_pc, imem_addr); end
  endtask

  task automatic test_btb_hit();
    redirect_nt(32'h104);
    total++; if (imem_addr !== 32'h108) begin bad++; $display("FAIL hit_redir got=%h exp=108", imem_addr); end
    bht_taken = 1;
    tick();
    total++; if (imem_addr !== 32'h200) begin bad++; $display("FAIL hit_next got=%h exp=200", imem_addr); end
    total++; if (if_id_pc !== 32'h108 || if_id_pred_taken !== 1'b1 || if_id_pred_target !== 32'h200) begin bad++;
      $display("FAIL hit_ifid got=%h/%b/%h exp=108/1/200", if_id_pc, if_id_pred_taken, if_id_pred_target); end
    bht_taken = 0;
    redirect_nt(32'h1104);
    bht_taken = 1;
    tick();
    total++; if (imem_addr !== 32'h110C) begin bad++; $display("FAIL alias_next got=%h exp=110c", imem_addr); end
    total++; if (if_id_pred_taken !== 1'b0 || if_id_pred_target !== 32'h0) begin bad++;
      $display("FAIL alias_ifid got=%b/%h exp=0/0", if_id_pred_taken, if_id_pred_target); end
    bht_taken = 0;
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (imem_addr !== 32'h110C || if_id_pc !== 32'h1108 || if_id_valid !== 1'b1 ||
                   if_id_instr !== 32'hDEAD_1108) begin bad++;
        $display("FAIL stall_hold%0d got=%h/%h/%b/%h exp=110c/1108/1/dead1108", i, imem_addr, if_id_pc, if_id_valid, if_id_instr); end
    end
    // Target mismatch on a taken branch during stall: redirect must win.
    ex_valid = 1; ex_pc = 32'h400; ex_taken = 1; ex_target = 32'h500; ex_pred_taken = 1; ex_pred_target = 32'h504;
    tick();
    ex_clear(); stall = 0;
    total++; if (imem_addr !== 32'h500 || if_id_valid !== 1'b0) begin bad++;
      $display("FAIL stall_mp got=%h/%b exp=500/0", imem_addr, if_id_valid); end
  endtask

  task automatic test_not_taken();
    ex_valid = 1; ex_pc = 32'h108; ex_taken = 0; ex_target = 0; ex_pred_taken = 1; ex_pred_target = 32'h200;
    #1;
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL nt_flag got=%b exp=1", mispredict); end
    tick();
    ex_clear();
    total++; if (imem_addr !== 32'h10C) begin bad++; $display("FAIL nt_pc got=%h exp=10c", imem_addr); end
    redirect_nt(32'h104);
    // Correctly predicted taken branch rewrites idx 2 while 0x108 looks it up: old target used.
    bht_taken = 1;
    ex_valid = 1; ex_pc = 32'h1108; ex_taken = 1; ex_target = 32'h600; ex_pred_taken = 1; ex_pred_target = 32'h600;
    #1;
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL ok_pred_flag got=%b exp=0", mispredict); end
    tick();
    ex_clear(); bht_taken = 0;
    total++; if (imem_addr !== 32'h200 || if_id_pred_taken !== 1'b1) begin bad++;
      $display("FAIL nt_retain got=%h/%b exp=200/1", imem_addr, if_id_pred_taken); end
  endtask

  task automatic test_wrap_and_reset();
    // Low target bits are dropped on load.
    ex_valid = 1; ex_pc = 32'h0; ex_taken = 1; ex_target = 32'hFFFF_FFFF; ex_pred_taken = 0; ex_pred_target = 0;
    tick();
    ex_clear();
    total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_load got=%h exp=fffffffc", imem_addr); end
    tick();
    total++; if (imem_addr !== 32'h0 || if_id_pc !== 32'hFFFF_FFFC) begin bad++;
      $display("FAIL wrap got=%h/%h exp=0/fffffffc", imem_addr, if_id_pc); end
    bht_taken = 1;
    tick();
    bht_taken = 0;
    total++; if (imem_addr !== 32'hFFFF_FFFC || if_id_pred_taken !== 1'b1) begin bad++;
      $display("FAIL pre_rst_hit got=%h/%b exp=fffffffc/1", imem_addr, if_id_pred_taken); end
    tick();
    #2 reset = 1;
    #1;
    total++; if (imem_addr !== 32'h100 || if_id_valid !== 1'b0 || if_id_instr !== 32'h13 || if_id_pc !== 32'h0) begin bad++;
      $display("FAIL async_rst got=%h/%b/%h/%h exp=100/0/00000013/0", imem_addr, if_id_valid, if_id_instr, if_id_pc); end
    tick();
    reset = 0;
    tick();
    total++; if (if_id_pc !== 32'h100 || imem_addr !== 32'h104) begin bad++;
      $display("FAIL post_rst_fetch got=%h/%h exp=100/104", if_id_pc, imem_addr); end
    redirect_nt(32'hFFFF_FFFC);
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL nt_wrap got=%h exp=0", imem_addr); end
    bht_taken = 1;
    tick();
    bht_taken = 0;
    total++; if (imem_addr !== 32'h4 || if_id_pred_taken !== 1'b0) begin bad++;
      $display("FAIL btb_empty got=%h/%b exp=4/0", imem_addr, if_id_pred_taken); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_mispredict();
    test_btb_hit();
    test_stall();
    test_not_taken();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
